hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Producer-side counterpart to the operand forwarding network in the RV32IM core.
- Forwarding delivers in-flight results once they exist. This block detects the cases where a result does not exist yet:
  - load-use
  - pending multi-cycle DIV/REM result (GPR or CSR)
  - data-bus wait
  - control redirect
- It drives per-stage stall and bubble (flush) controls for the 5-stage pipeline, and tracks long-latency writers in a register scoreboard.

Parameters:
- DIV_TIMEOUT, 40, max cycles a divide may stay outstanding before it is force-retired with an error pulse.
- CNT_W, 32, width of the optional stall counters.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- id_rs1_addr_i  in  5  ID-stage source 1 register.
- id_rs1_re_i  in  1  ID reads rs1.
- id_rs2_addr_i  in  5  ID-stage source 2 register.
- id_rs2_re_i  in  1  ID reads rs2.
- id_rd_addr_i  in  5  ID-stage destination.
- id_rdwe_i  in  1  ID instruction writes rd.
- id_is_div_i  in  1  ID instruction is DIV/DIVU/REM/REMU.
- exe_rdaddr_i  in  5  EXE-stage destination.
- exe_rdwe_i  in  1  EXE writes rd.
- exe_memrd_i  in  1  EXE instruction is a load.
- div_start_i  in  1  divider accepts an op this cycle.
- div_rdaddr_i  in  5  destination of the accepted divide.
- div_done_i  in  1  divider result valid (retires into WB).
- mem_req_i  in  1  MEM stage has a bus access.
- dbus_ready_i  in  1  data bus completes this cycle.
- jump_req_i  in  1  EXE redirect (branch taken/jal/jalr).
- trap_flush_i  in  1  trap/mret flush; also kills the divider.
- stall_o  out  5  hold stage register; bit0 PC, 1 IF/ID, 2 ID/EXE, 3 EXE/MEM, 4 MEM/WB.
- flush_o  out  5  load bubble into stage register; same bit map.
- div_err_o  out  1  one-cycle pulse on divide timeout.
- div_busy_o  out  1  a divide is outstanding.
- cnt_loaduse_o  out  CNT_W  load-use stall cycles.
- cnt_div_o  out  CNT_W  divide stall cycles.
- cnt_mem_o  out  CNT_W  bus-wait stall cycles.

Behaviour:
- Reset:
  - Clears the scoreboard (32-bit pending vector), FSM to RUN, timeout counter to 0.
  - stall_o=0, flush_o=0, div_err_o=0, div_busy_o=0, all counters 0.
- Register x0 never hazards; matches against address 0 are ignored.
- FSM states: RUN, DIV_BUSY.
  - RUN → DIV_BUSY on div_start_i.
  - DIV_BUSY → RUN on div_done_i, on timeout, or on trap_flush_i.
  - The divider is single-outstanding.
- Scoreboard:
  - div_start_i sets pend[div_rdaddr_i] at the next edge.
  - div_done_i clears the bit latched at start.
  - Same-cycle done + start: the clear applies first, then the set (set wins if the same address).
  - trap_flush_i or timeout clears the whole vector.
- Timeout counter:
  - Counts while in DIV_BUSY; resets on each start.
  - Reaching DIV_TIMEOUT gives: div_err_o=1 for one cycle, return to RUN, clear the scoreboard.
- div_busy_o = (state == DIV_BUSY), registered.
- Hazard terms (combinational from current inputs/state, zero-cycle latency):
  - LU (load-use): exe_memrd_i & exe_rdwe_i & rd≠0 & (rs1 match & rs1_re | rs2 match & rs2_re).
  - SB (scoreboard): any of the following:
    - a read of a pending register;
    - id_rdwe_i to a pending register (WAW);
    - id_is_div_i while div_busy_o.
  - MW (memory wait): mem_req_i & ~dbus_ready_i.
- Priority and resulting controls (first match wins):
  1. trap_flush_i: flush_o=5'b01111, stall_o=0.
  2. MW: stall_o=5'b01111, flush_o=5'b10000 (WB bubble). A jump during MW is held because EXE is stalled; jump_req_i stays asserted.
  3. jump_req_i: flush_o=5'b00110 (kill IF/ID and ID/EXE), stall_o=0. This overrides LU/SB because the ID instruction is discarded.
  4. SB or LU: stall_o=5'b00011, flush_o=5'b00100.
  5. Otherwise all zeros.
- A load-use stall lasts exactly one cycle. The next cycle the load is in MEM and the forwarding path supplies the data.
- An SB stall holds until the bit clears. Release occurs the cycle after div_done_i, since the WB value is then forwardable.
- Reset asserted mid-stall: all outputs return to 0 at the next edge, and any in-flight divide is forgotten.

Optional Feature:
- HAZARD_STALL_CNT_EN defined:
  - Each counter increments by 1 on every cycle its cause wins priority.
  - Counters saturate at all-ones and clear on rst.
- HAZARD_STALL_CNT_EN undefined: counter outputs are constant 0 and no counter flops are built.

Decomposition:
- Add to defines.v:
  - stage bit indices STG_PC..STG_WB;
  - state encodings HZ_RUN/HZ_DIVBUSY;
  - the constant vectors for each priority case.
- Natural sub-module: hazard_scoreboard, covering the pend vector, FSM and timeout counter, with outputs pend[31:0], div_busy, div_err. The top adds match logic, priority and counters.

Test Plan:
- Load x5 in EXE, ID `add x6,x5,x1` with rs1_re=1 → one cycle of stall_o=00011, flush_o=00100; next cycle all 0.
- Same load with destination x0, ID reads x0 → no stall.
- div_start_i for x7, ID reads x7 for 10 cycles, then div_done_i → stall held 10 cycles, released the cycle after done; div_busy_o 1→0.
- div_start_i with no done for DIV_TIMEOUT=40 cycles → div_err_o pulses at cycle 40, pend cleared, stall drops.
- mem_req_i=1, dbus_ready_i=0 for 3 cycles with jump_req_i=1 → stall_o=01111 and flush_o=10000 for 3 cycles, then flush_o=00110.
- LU and jump_req_i in the same cycle → flush_o=00110, stall_o=0. With HAZARD_STALL_CNT_EN, cnt_loaduse_o is unchanged.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared stage indices, divider FSM states and the stall/flush vectors for each priority case.
package hazard_ctrl_pkg;

  localparam int unsigned StgPc     = 0;
  localparam int unsigned StgIfId   = 1;
  localparam int unsigned StgIdExe  = 2;
  localparam int unsigned StgExeMem = 3;
  localparam int unsigned StgMemWb  = 4;

  typedef enum logic {
    HzRun     = 1'b0,
    HzDivBusy = 1'b1
  } hz_state_e;

  localparam logic [4:0] VecNone = 5'b00000;
  // Everything up to and including EXE/MEM is either killed or frozen.
  localparam logic [4:0] VecFront = (5'b1 << StgPc) | (5'b1 << StgIfId) |
                                    (5'b1 << StgIdExe) | (5'b1 << StgExeMem);
  localparam logic [4:0] FlushTrap    = VecFront;
  localparam logic [4:0] StallMemWait = VecFront;
  localparam logic [4:0] FlushMemWait = 5'b1 << StgMemWb;
  localparam logic [4:0] FlushJump    = (5'b1 << StgIfId) | (5'b1 << StgIdExe);
  localparam logic [4:0] StallHazard  = (5'b1 << StgPc) | (5'b1 << StgIfId);
  localparam logic [4:0] FlushHazard  = 5'b1 << StgIdExe;

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-writer scoreboard for the single-outstanding divider, with its FSM and timeout.
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start_i,
  input  logic [4:0]  div_rdaddr_i,
  input  logic        div_done_i,
  input  logic        trap_flush_i,
  output logic [31:0] pend_o,
  output logic        div_busy_o,
  output logic        div_err_o
);

  localparam int unsigned TmoW = $clog2(DIV_TIMEOUT + 1);

  hz_state_e         state_q, state_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [31:0]       pend_q, pend_d;
  logic [4:0]        rd_q, rd_d;
  logic              err_q, err_d;
  logic              timeout;

  always_comb begin
    timeout = (state_q == HzDivBusy) && !div_done_i && (tmo_q == TmoW'(DIV_TIMEOUT - 1));
    state_d = state_q;
    tmo_d   = tmo_q;
    pend_d  = pend_q;
    rd_d    = rd_q;
    err_d   = 1'b0;
    if (trap_flush_i) begin
      pend_d  = '0;
      state_d = HzRun;
    end else begin
      if (state_q == HzDivBusy) begin
        tmo_d = tmo_q + 1'b1;
        if (div_done_i) begin
          pend_d[rd_q] = 1'b0;
          state_d      = HzRun;
        end else if (timeout) begin
          pend_d  = '0;
          state_d = HzRun;
          err_d   = 1'b1;
        end
      end
      // Set after clear so a back-to-back divide to the same rd stays pending.
      if (div_start_i) begin
        pend_d[div_rdaddr_i] = 1'b1;
        rd_d                 = div_rdaddr_i;
        state_d              = HzDivBusy;
        tmo_d                = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HzRun;
      tmo_q   <= '0;
      pend_q  <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      pend_q  <= pend_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  assign pend_o     = pend_q;
  assign div_busy_o = (state_q == HzDivBusy);
  assign div_err_o  = err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard detection: load-use, divider scoreboard, bus wait and redirect priority.
// Optional stall counters are built when HAZARD_STALL_CNT_EN is defined.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_TIMEOUT = 40,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic             id_rs1_re_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs2_re_i,
  input  logic [4:0]       id_rd_addr_i,
  input  logic             id_rdwe_i,
  input  logic             id_is_div_i,
  input  logic [4:0]       exe_rdaddr_i,
  input  logic             exe_rdwe_i,
  input  logic             exe_memrd_i,
  input  logic             div_start_i,
  input  logic [4:0]       div_rdaddr_i,
  input  logic             div_done_i,
  input  logic             mem_req_i,
  input  logic             dbus_ready_i,
  input  logic             jump_req_i,
  input  logic             trap_flush_i,
  output logic [4:0]       stall_o,
  output logic [4:0]       flush_o,
  output logic             div_err_o,
  output logic             div_busy_o,
  output logic [CNT_W-1:0] cnt_loaduse_o,
  output logic [CNT_W-1:0] cnt_div_o,
  output logic [CNT_W-1:0] cnt_mem_o
);

  logic [31:0] pend;
  logic        lu, sb, mw;
  logic        rs1_hit, rs2_hit, waw_hit;

  hazard_scoreboard #(
    .DIV_TIMEOUT(DIV_TIMEOUT)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .div_start_i (div_start_i),
    .div_rdaddr_i(div_rdaddr_i),
    .div_done_i  (div_done_i),
    .trap_flush_i(trap_flush_i),
    .pend_o      (pend),
    .div_busy_o  (div_busy_o),
    .div_err_o   (div_err_o)
  );

  always_comb begin
    lu = exe_memrd_i && exe_rdwe_i && (exe_rdaddr_i != 5'd0) &&
         ((id_rs1_re_i && (id_rs1_addr_i == exe_rdaddr_i)) ||
          (id_rs2_re_i && (id_rs2_addr_i == exe_rdaddr_i)));
    rs1_hit = id_rs1_re_i && (id_rs1_addr_i != 5'd0) && pend[id_rs1_addr_i];
    rs2_hit = id_rs2_re_i && (id_rs2_addr_i != 5'd0) && pend[id_rs2_addr_i];
    waw_hit = id_rdwe_i && (id_rd_addr_i != 5'd0) && pend[id_rd_addr_i];
    sb      = rs1_hit || rs2_hit || waw_hit || (id_is_div_i && div_busy_o);
    mw      = mem_req_i && !dbus_ready_i;
  end

  always_comb begin
    stall_o = VecNone;
    flush_o = VecNone;
    if (!rst) begin
      if (trap_flush_i) begin
        flush_o = FlushTrap;
      end else if (mw) begin
        stall_o = StallMemWait;
        flush_o = FlushMemWait;
      end else if (jump_req_i) begin
        flush_o = FlushJump;
      end else if (sb || lu) begin
        stall_o = StallHazard;
        flush_o = FlushHazard;
      end
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic             win_mw, win_hz;
  logic [CNT_W-1:0] cnt_lu_q, cnt_lu_d, cnt_div_q, cnt_div_d, cnt_mem_q, cnt_mem_d;

  assign win_mw = !rst && !trap_flush_i && mw;
  assign win_hz = !rst && !trap_flush_i && !mw && !jump_req_i;

  always_comb begin
    cnt_lu_d  = cnt_lu_q;
    cnt_div_d = cnt_div_q;
    cnt_mem_d = cnt_mem_q;
    if (win_hz && lu && !(&cnt_lu_q))   cnt_lu_d  = cnt_lu_q + 1'b1;
    if (win_hz && sb && !(&cnt_div_q))  cnt_div_d = cnt_div_q + 1'b1;
    if (win_mw && !(&cnt_mem_q))        cnt_mem_d = cnt_mem_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lu_q  <= '0;
      cnt_div_q <= '0;
      cnt_mem_q <= '0;
    end else begin
      cnt_lu_q  <= cnt_lu_d;
      cnt_div_q <= cnt_div_d;
      cnt_mem_q <= cnt_mem_d;
    end
  end

  assign cnt_loaduse_o = cnt_lu_q;
  assign cnt_div_o     = cnt_div_q;
  assign cnt_mem_o     = cnt_mem_q;
`else
  assign cnt_loaduse_o = '0;
  assign cnt_div_o     = '0;
  assign cnt_mem_o     = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized run against a model.
module tb_hazard_ctrl;

  localparam int unsigned DivTo = 40;
  localparam int unsigned CntW  = 32;
`ifdef HAZARD_STALL_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic            clk, rst;
  logic [4:0]      id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, exe_rdaddr_i, div_rdaddr_i;
  logic            id_rs1_re_i, id_rs2_re_i, id_rdwe_i, id_is_div_i, exe_rdwe_i, exe_memrd_i;
  logic            div_start_i, div_done_i, mem_req_i, dbus_ready_i, jump_req_i, trap_flush_i;
  logic [4:0]      stall_o, flush_o;
  logic            div_err_o, div_busy_o;
  logic [CntW-1:0] cnt_loaduse_o, cnt_div_o, cnt_mem_o;

  int n_checks = 0;
  int n_err    = 0;

  hazard_ctrl #(.DIV_TIMEOUT(DivTo), .CNT_W(CntW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs1_re_i(id_rs1_re_i),
    .id_rs2_addr_i(id_rs2_addr_i), .id_rs2_re_i(id_rs2_re_i),
    .id_rd_addr_i(id_rd_addr_i), .id_rdwe_i(id_rdwe_i), .id_is_div_i(id_is_div_i),
    .exe_rdaddr_i(exe_rdaddr_i), .exe_rdwe_i(exe_rdwe_i), .exe_memrd_i(exe_memrd_i),
    .div_start_i(div_start_i), .div_rdaddr_i(div_rdaddr_i), .div_done_i(div_done_i),
    .mem_req_i(mem_req_i), .dbus_ready_i(dbus_ready_i), .jump_req_i(jump_req_i),
    .trap_flush_i(trap_flush_i), .stall_o(stall_o), .flush_o(flush_o),
    .div_err_o(div_err_o), .div_busy_o(div_busy_o), .cnt_loaduse_o(cnt_loaduse_o),
    .cnt_div_o(cnt_div_o), .cnt_mem_o(cnt_mem_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_rs1_addr_i = '0; id_rs1_re_i = 0; id_rs2_addr_i = '0; id_rs2_re_i = 0;
    id_rd_addr_i = '0; id_rdwe_i = 0; id_is_div_i = 0; exe_rdaddr_i = '0; exe_rdwe_i = 0;
    exe_memrd_i = 0; div_start_i = 0; div_rdaddr_i = '0; div_done_i = 0; mem_req_i = 0;
    dbus_ready_i = 0; jump_req_i = 0; trap_flush_i = 0;
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1);
    exe_rdaddr_i = rd; exe_rdwe_i = 1; exe_memrd_i = 1;
    id_rs1_addr_i = rs1; id_rs1_re_i = 1; id_rs2_addr_i = 5'd1; id_rs2_re_i = 1;
    id_rd_addr_i = 5'd6; id_rdwe_i = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    set_load_use(5'd5, 5'd5);
    step();
    n_checks++; if (stall_o !== 5'b0) begin n_err++; $display("FAIL reset_stall got %b want 00000", stall_o); end
    n_checks++; if (flush_o !== 5'b0) begin n_err++; $display("FAIL reset_flush got %b want 00000", flush_o); end
    n_checks++; if (div_busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", div_busy_o); end
    n_checks++; if (div_err_o !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", div_err_o); end
    n_checks++; if ({cnt_loaduse_o, cnt_div_o, cnt_mem_o} !== '0) begin
      n_err++; $display("FAIL reset_cnt got %0d/%0d/%0d want 0/0/0", cnt_loaduse_o, cnt_div_o, cnt_mem_o);
    end
    rst = 1'b0;
    clear_inputs();
    #1;
    n_checks++; if ({stall_o, flush_o} !== 10'b0) begin n_err++; $display("FAIL idle_ctrl got %b want 0", {stall_o, flush_o}); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use(5'd5, 5'd5);
    #1;
    n_checks++; if (stall_o !== 5'b00011) begin n_err++; $display("FAIL lu_stall got %b want 00011", stall_o); end
    n_checks++; if (flush_o !== 5'b00100) begin n_err++; $display("FAIL lu_flush got %b want 00100", flush_o); end
    step();
    exe_memrd_i = 0; exe_rdwe_i = 0; exe_rdaddr_i = '0;
    #1;
    n_checks++; if ({stall_o, flush_o} !== 10'b0) begin n_err++; $display("FAIL lu_release got %b want 0", {stall_o, flush_o}); end
    n_checks++; if (cnt_loaduse_o !== (CntEn ? CntW'(1) : CntW'(0))) begin
      n_err++; $display("FAIL lu_cnt got %0d want %0d", cnt_loaduse_o, CntEn ? 1 : 0);
    end
    // Load to x0 with ID reading x0 must not stall.
    set_load_use(5'd0, 5'd0);
    id_rs2_addr_i = 5'd0;
    #1;
    n_checks++; if ({stall_o, flush_o} !== 10'b0) begin n_err++; $display("FAIL lu_x0 got %b want 0", {stall_o, flush_o}); end
  endtask

  task automatic test_div_stall();
    do_reset();
    div_start_i = 1; div_rdaddr_i = 5'd7;
    step();
    div_start_i = 0;
    id_rs1_addr_i = 5'd7; id_rs1_re_i = 1;
    for (int i = 0; i < 10; i++) begin
      div_done_i = (i == 9);
      #1;
      n_checks++; if (stall_o !== 5'b00011 || flush_o !== 5'b00100) begin
        n_err++; $display("FAIL div_hold[%0d] got %b/%b want 00011/00100", i, stall_o, flush_o);
      end
      n_checks++; if (div_busy_o !== 1'b1) begin n_err++; $display("FAIL div_busy[%0d] got %b want 1", i, div_busy_o); end
      step();
    end
    div_done_i = 0;
    #1;
    n_checks++; if ({stall_o, flush_o} !== 10'b0) begin n_err++; $display("FAIL div_release got %b want 0", {stall_o, flush_o}); end
    n_checks++; if (div_busy_o !== 1'b0) begin n_err++; $display("FAIL div_idle got %b want 0", div_busy_o); end
  endtask

  task automatic test_timeout();
    do_reset();
    div_start_i = 1; div_rdaddr_i = 5'd9;
    step();
    div_start_i = 0;
    id_rs2_addr_i = 5'd9; id_rs2_re_i = 1;
    for (int i = 0; i < int'(DivTo); i++) begin
      #1;
      n_checks++; if (div_err_o !== 1'b0 || stall_o !== 5'b00011 || div_busy_o !== 1'b1) begin
        n_err++; $display("FAIL tmo_wait[%0d] got err=%b stall=%b busy=%b want 0/00011/1", i, div_err_o, stall_o, div_busy_o);
      end
      step();
    end
    #1;
    n_checks++; if (div_err_o !== 1'b1) begin n_err++; $display("FAIL tmo_pulse got %b want 1", div_err_o); end
    n_checks++; if (div_busy_o !== 1'b0 || stall_o !== 5'b0) begin
      n_err++; $display("FAIL tmo_clear got busy=%b stall=%b want 0/00000", div_busy_o, stall_o);
    end
    step();
    n_checks++; if (div_err_o !== 1'b0) begin n_err++; $display("FAIL tmo_oneshot got %b want 0", div_err_o); end
  endtask

  task automatic test_mem_wait_jump();
    do_reset();
    mem_req_i = 1; dbus_ready_i = 0; jump_req_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (stall_o !== 5'b01111 || flush_o !== 5'b10000) begin
        n_err++; $display("FAIL mw[%0d] got %b/%b want 01111/10000", i, stall_o, flush_o);
      end
      step();
    end
    dbus_ready_i = 1;
    #1;
    n_checks++; if (stall_o !== 5'b0 || flush_o !== 5'b00110) begin
      n_err++; $display("FAIL mw_jump got %b/%b want 00000/00110", stall_o, flush_o);
    end
    trap_flush_i = 1; dbus_ready_i = 0;
    #1;
    n_checks++; if (stall_o !== 5'b0 || flush_o !== 5'b01111) begin
      n_err++; $display("FAIL trap got %b/%b want 00000/01111", stall_o, flush_o);
    end
  endtask

  task automatic test_lu_jump();
    do_reset();
    set_load_use(5'd5, 5'd5);
    jump_req_i = 1;
    #1;
    n_checks++; if (stall_o !== 5'b0 || flush_o !== 5'b00110) begin
      n_err++; $display("FAIL lu_jump got %b/%b want 00000/00110", stall_o, flush_o);
    end
    step();
    n_checks++; if (cnt_loaduse_o !== CntW'(0)) begin n_err++; $display("FAIL lu_jump_cnt got %0d want 0", cnt_loaduse_o); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    div_start_i = 1; div_rdaddr_i = 5'd3;
    step();
    div_start_i = 0; id_rs1_addr_i = 5'd3; id_rs1_re_i = 1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_checks++; if (stall_o !== 5'b0 || div_busy_o !== 1'b0) begin
      n_err++; $display("FAIL rst_mid got stall=%b busy=%b want 00000/0", stall_o, div_busy_o);
    end
  endtask

  task automatic test_random();
    bit pend [32];
    bit busy, err, lu, sb, mw;
    int age;
    logic [4:0] lat_rd, es, ef;
    longint unsigned c_lu, c_div, c_mem;
    do_reset();
    pend = '{default: 1'b0};
    busy = 0; err = 0; age = 0; lat_rd = '0; c_lu = 0; c_div = 0; c_mem = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      id_rs1_addr_i = 5'($urandom_range(0, 7)); id_rs1_re_i = 1'($urandom);
      id_rs2_addr_i = 5'($urandom_range(0, 7)); id_rs2_re_i = 1'($urandom);
      id_rd_addr_i  = 5'($urandom_range(0, 7)); id_rdwe_i   = 1'($urandom);
      id_is_div_i   = ($urandom_range(0, 7) == 0);
      exe_rdaddr_i  = 5'($urandom_range(0, 7)); exe_rdwe_i = 1'($urandom);
      exe_memrd_i   = ($urandom_range(0, 2) == 0);
      div_done_i    = busy && ($urandom_range(0, 29) == 0);
      div_start_i   = (!busy || div_done_i) && ($urandom_range(0, 5) == 0);
      div_rdaddr_i  = 5'($urandom_range(0, 7));
      mem_req_i     = ($urandom_range(0, 3) == 0); dbus_ready_i = 1'($urandom);
      jump_req_i    = ($urandom_range(0, 7) == 0);
      trap_flush_i  = ($urandom_range(0, 63) == 0);
      #1;
      lu = exe_memrd_i && exe_rdwe_i && exe_rdaddr_i != 0 &&
           ((id_rs1_re_i && id_rs1_addr_i == exe_rdaddr_i) || (id_rs2_re_i && id_rs2_addr_i == exe_rdaddr_i));
      sb = (id_rs1_re_i && id_rs1_addr_i != 0 && pend[id_rs1_addr_i]) ||
           (id_rs2_re_i && id_rs2_addr_i != 0 && pend[id_rs2_addr_i]) ||
           (id_rdwe_i && id_rd_addr_i != 0 && pend[id_rd_addr_i]) || (id_is_div_i && busy);
      mw = mem_req_i && !dbus_ready_i;
      es = 5'b0; ef = 5'b0;
      if (trap_flush_i) ef = 5'b01111;
      else if (mw) begin es = 5'b01111; ef = 5'b10000; end
      else if (jump_req_i) ef = 5'b00110;
      else if (sb || lu) begin es = 5'b00011; ef = 5'b00100; end
      n_checks++; if (stall_o !== es) begin n_err++; $display("FAIL rnd_stall@%0d got %b want %b", cyc, stall_o, es); end
      n_checks++; if (flush_o !== ef) begin n_err++; $display("FAIL rnd_flush@%0d got %b want %b", cyc, flush_o, ef); end
      n_checks++; if (div_busy_o !== busy) begin n_err++; $display("FAIL rnd_busy@%0d got %b want %b", cyc, div_busy_o, busy); end
      n_checks++; if (div_err_o !== err) begin n_err++; $display("FAIL rnd_err@%0d got %b want %b", cyc, div_err_o, err); end
      n_checks++; if (cnt_loaduse_o !== CntW'(CntEn ? c_lu : 0) || cnt_div_o !== CntW'(CntEn ? c_div : 0) ||
                      cnt_mem_o !== CntW'(CntEn ? c_mem : 0)) begin
        n_err++; $display("FAIL rnd_cnt@%0d got %0d/%0d/%0d want %0d/%0d/%0d", cyc, cnt_loaduse_o, cnt_div_o,
                          cnt_mem_o, CntEn ? c_lu : 0, CntEn ? c_div : 0, CntEn ? c_mem : 0);
      end
      if (!trap_flush_i && mw) c_mem++;
      if (!trap_flush_i && !mw && !jump_req_i) begin
        if (lu) c_lu++;
        if (sb) c_div++;
      end
      step();
      err = 0;
      if (trap_flush_i) begin
        pend = '{default: 1'b0}; busy = 0;
      end else begin
        if (busy) begin
          if (div_done_i) begin pend[lat_rd] = 0; busy = 0; end
          else if (age == int'(DivTo) - 1) begin pend = '{default: 1'b0}; busy = 0; err = 1; end
          else age++;
        end
        if (div_start_i) begin pend[div_rdaddr_i] = 1; lat_rd = div_rdaddr_i; busy = 1; age = 0; end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_div_stall();
    test_timeout();
    test_mem_wait_jump();
    test_lu_jump();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
